// File: rtl/pcs_tx_code_group_pkg.sv
// ============================================================================
//  Module      : pcs_tx_pkg
//  Description : Shared ordered-set codes, K-code octets and FSM state
//                encodings for the 1000BASE-X transmit code-group generator.
//                Config ordered-set support is built when PCS_TX_CONFIG_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcs_tx_pkg;

    localparam logic [2:0] O_SET_I    = 3'b000;
    localparam logic [2:0] O_SET_D    = 3'b001;
    localparam logic [2:0] O_SET_S    = 3'b010;
    localparam logic [2:0] O_SET_T    = 3'b011;
    localparam logic [2:0] O_SET_R    = 3'b100;
    localparam logic [2:0] O_SET_V    = 3'b101;
    localparam logic [2:0] O_SET_C    = 3'b110;
    localparam logic [2:0] O_SET_RSVD = 3'b111;

    // K-code octets in HGF_EDCBA form
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;

    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
`ifdef PCS_TX_CONFIG_EN
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
`endif

    typedef enum logic [3:0] {
        ST_GENERATE   = 4'd0,
        ST_IDLE_2     = 4'd1
`ifdef PCS_TX_CONFIG_EN
        ,
        ST_CONFIG_C1B = 4'd2,
        ST_CONFIG_C1C = 4'd3,
        ST_CONFIG_C1D = 4'd4,
        ST_CONFIG_C2A = 4'd5,
        ST_CONFIG_C2B = 4'd6,
        ST_CONFIG_C2C = 4'd7,
        ST_CONFIG_C2D = 4'd8
`endif
    } tx_state_e;

    function automatic logic [3:0] pop10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcs_tx_code_group_enc_8b10b.sv
// ============================================================================
//  Module      : enc_8b10b
//  Description : Combinational 8b/10b encoder (abcdei_fghj, 'a' at bit 9)
//                with per-sub-block running disparity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_8b10b
    import pcs_tx_pkg::*;
(
    input  logic [7:0] data,
    input  logic       k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [5:0] six_neg;
    logic [5:0] six;
    logic [3:0] four_neg;
    logic [3:0] four;
    logic       six_bal;
    logic       four_bal;
    logic       rd_mid;
    logic       use_a7;
    logic [9:0] k_neg;
    logic       k_hit;
    logic [9:0] d_code;

    always_comb begin
        six_neg = 6'b000000;
        case (data[4:0])
            5'd0:  six_neg = 6'b100111;
            5'd1:  six_neg = 6'b011101;
            5'd2:  six_neg = 6'b101101;
            5'd3:  six_neg = 6'b110001;
            5'd4:  six_neg = 6'b110101;
            5'd5:  six_neg = 6'b101001;
            5'd6:  six_neg = 6'b011001;
            5'd7:  six_neg = 6'b111000;
            5'd8:  six_neg = 6'b111001;
            5'd9:  six_neg = 6'b100101;
            5'd10: six_neg = 6'b010101;
            5'd11: six_neg = 6'b110100;
            5'd12: six_neg = 6'b001101;
            5'd13: six_neg = 6'b101100;
            5'd14: six_neg = 6'b011100;
            5'd15: six_neg = 6'b010111;
            5'd16: six_neg = 6'b011011;
            5'd17: six_neg = 6'b100011;
            5'd18: six_neg = 6'b010011;
            5'd19: six_neg = 6'b110010;
            5'd20: six_neg = 6'b001011;
            5'd21: six_neg = 6'b101010;
            5'd22: six_neg = 6'b011010;
            5'd23: six_neg = 6'b111010;
            5'd24: six_neg = 6'b110011;
            5'd25: six_neg = 6'b100110;
            5'd26: six_neg = 6'b010110;
            5'd27: six_neg = 6'b110110;
            5'd28: six_neg = 6'b001110;
            5'd29: six_neg = 6'b101110;
            5'd30: six_neg = 6'b011110;
            5'd31: six_neg = 6'b101011;
        endcase

        six_bal = (pop10({4'd0, six_neg}) == 4'd3);
        // D.7 is balanced but still alternates to bound run length
        six     = (rd_in && (!six_bal || six_neg == 6'b111000)) ? ~six_neg : six_neg;
        rd_mid  = six_bal ? rd_in : ~rd_in;

        use_a7 = (!rd_mid && (data[4:0] == 5'd17 || data[4:0] == 5'd18 || data[4:0] == 5'd20)) ||
                 ( rd_mid && (data[4:0] == 5'd11 || data[4:0] == 5'd13 || data[4:0] == 5'd14));

        four_neg = 4'b0000;
        case (data[7:5])
            3'd0: four_neg = 4'b1011;
            3'd1: four_neg = 4'b1001;
            3'd2: four_neg = 4'b0101;
            3'd3: four_neg = 4'b1100;
            3'd4: four_neg = 4'b1101;
            3'd5: four_neg = 4'b1010;
            3'd6: four_neg = 4'b0110;
            3'd7: four_neg = use_a7 ? 4'b0111 : 4'b1110;
        endcase

        four_bal = (pop10({6'd0, four_neg}) == 4'd2);
        four     = (rd_mid && (!four_bal || four_neg == 4'b1100)) ? ~four_neg : four_neg;
        d_code   = {six, four};

        k_hit = 1'b1;
        k_neg = 10'b0;
        case (data)
            K28_5:   k_neg = 10'b0011111010;
            K27_7:   k_neg = 10'b1101101000;
            K29_7:   k_neg = 10'b1011101000;
            K23_7:   k_neg = 10'b1110101000;
            K30_7:   k_neg = 10'b0111101000;
            default: k_hit = 1'b0;
        endcase

        if (k && k_hit) begin
            code   = rd_in ? ~k_neg : k_neg;
            rd_out = (pop10(k_neg) == 4'd5) ? rd_in : ~rd_in;
        end else begin
            code   = d_code;
            rd_out = four_bal ? rd_mid : ~rd_mid;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcs_tx_code_group.sv
// ============================================================================
//  Module      : pcs_tx_code_group
//  Description : 1000BASE-X PCS transmit code-group generator with idle
//                alignment; /C/ config sequences built with PCS_TX_CONFIG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcs_tx_code_group
    import pcs_tx_pkg::*;
(
    input  logic        clk,
    input  logic        mr_main_reset,
    input  logic [2:0]  tx_o_set,
    input  logic [7:0]  txd,
`ifdef PCS_TX_CONFIG_EN
    input  logic [15:0] tx_config_reg,
`endif
    output logic        tx_o_set_ack,
    output logic [9:0]  tx_code_group,
    output logic        tx_even,
    output logic        tx_disparity
);

    tx_state_e  state_q;
    logic [9:0] code_q;
    logic       even_q;
    logic       disp_q;
    logic       ack_q;
`ifdef PCS_TX_CONFIG_EN
    logic [15:0] cfg_q;
`endif

    logic [7:0] w_enc_data;
    logic       w_enc_k;
    logic [9:0] w_enc_code;
    logic       w_enc_rd;
    logic       w_even_slot;
    logic       w_idle_req;

    assign w_even_slot = ~even_q;
    assign w_idle_req  = (tx_o_set == O_SET_I) || (tx_o_set == O_SET_C);

    always_comb begin
        w_enc_data = K28_5;
        w_enc_k    = 1'b1;
        case (state_q)
            ST_GENERATE: begin
                case (tx_o_set)
                    O_SET_D: begin
                        w_enc_data = txd;
                        w_enc_k    = 1'b0;
                    end
                    O_SET_S:             w_enc_data = K27_7;
                    O_SET_T:             w_enc_data = K29_7;
                    O_SET_R:             w_enc_data = K23_7;
                    O_SET_V, O_SET_RSVD: w_enc_data = K30_7;
                    default:             w_enc_data = w_even_slot ? K28_5 : K23_7;
                endcase
            end
            ST_IDLE_2: begin
                // RD+ now means the K28.5 started from RD-, so /I2/ follows
                w_enc_k    = 1'b0;
                w_enc_data = disp_q ? D16_2 : D5_6;
            end
`ifdef PCS_TX_CONFIG_EN
            ST_CONFIG_C1B: begin w_enc_k = 1'b0; w_enc_data = D21_5;        end
            ST_CONFIG_C1C: begin w_enc_k = 1'b0; w_enc_data = cfg_q[7:0];   end
            ST_CONFIG_C1D: begin w_enc_k = 1'b0; w_enc_data = cfg_q[15:8];  end
            ST_CONFIG_C2A: begin w_enc_k = 1'b1; w_enc_data = K28_5;        end
            ST_CONFIG_C2B: begin w_enc_k = 1'b0; w_enc_data = D2_2;         end
            ST_CONFIG_C2C: begin w_enc_k = 1'b0; w_enc_data = cfg_q[7:0];   end
            ST_CONFIG_C2D: begin w_enc_k = 1'b0; w_enc_data = cfg_q[15:8];  end
`endif
            default: begin
                w_enc_k    = 1'b1;
                w_enc_data = K28_5;
            end
        endcase
    end

    enc_8b10b u_enc (
        .data   (w_enc_data),
        .k      (w_enc_k),
        .rd_in  (disp_q),
        .code   (w_enc_code),
        .rd_out (w_enc_rd)
    );

    always_ff @(posedge clk) begin
        if (!mr_main_reset) begin
            state_q <= ST_GENERATE;
            code_q  <= 10'b0;
            even_q  <= 1'b0;
            disp_q  <= 1'b0;
            ack_q   <= 1'b0;
`ifdef PCS_TX_CONFIG_EN
            cfg_q   <= 16'h0000;
`endif
        end else begin
            code_q <= w_enc_code;
            disp_q <= w_enc_rd;
            even_q <= ~even_q;
            ack_q  <= (state_q == ST_GENERATE);
            case (state_q)
                ST_GENERATE: begin
                    if (w_idle_req && w_even_slot) begin
                        state_q <= ST_IDLE_2;
                    end
`ifdef PCS_TX_CONFIG_EN
                    if (w_even_slot && tx_o_set == O_SET_C) begin
                        state_q <= ST_CONFIG_C1B;
                        cfg_q   <= tx_config_reg;
                    end
`endif
                end
                ST_IDLE_2:     state_q <= ST_GENERATE;
`ifdef PCS_TX_CONFIG_EN
                ST_CONFIG_C1B: state_q <= ST_CONFIG_C1C;
                ST_CONFIG_C1C: state_q <= ST_CONFIG_C1D;
                ST_CONFIG_C1D: state_q <= ST_CONFIG_C2A;
                ST_CONFIG_C2A: state_q <= ST_CONFIG_C2B;
                ST_CONFIG_C2B: state_q <= ST_CONFIG_C2C;
                ST_CONFIG_C2C: state_q <= ST_CONFIG_C2D;
                ST_CONFIG_C2D: state_q <= ST_GENERATE;
`endif
                default:       state_q <= ST_GENERATE;
            endcase
        end
    end

    assign tx_code_group = code_q;
    assign tx_even       = even_q;
    assign tx_disparity  = disp_q;
    assign tx_o_set_ack  = ack_q;

endmodule

`default_nettype wire
